pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised elastic replacement for the fixed IF/ID/EX/MEM/WB stage latches in the core.
- Moves a WIDTH-bit payload through STAGES registered slots using valid/ready handshakes.
- Collapses bubbles, so a stalled downstream stage does not freeze empty upstream slots.
- Kills individual stages with a per-stage flush mask (branch/jump redirect, load-use bubble), and exports slot occupancy to the hazard unit.

Parameters:
WIDTH, 32, payload bits per slot
STAGES, 4, number of slots (>=1); slot 0 = youngest, slot STAGES-1 = oldest
CW, $clog2(STAGES+1), width of the occupancy count

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears every slot
in_valid  in  1  upstream offers in_data
in_ready  out  1  slot 0 will capture this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  oldest slot holds a live entry
out_ready  in  1  downstream consumes the oldest entry this cycle
out_data  out  WIDTH  payload of slot STAGES-1
flush  in  STAGES  bit i kills the entry in slot i at this edge
stage_valid  out  STAGES  live bit per slot, for hazard checks
count  out  CW  number of live slots

Behaviour:
- Reset and state:
  - One synchronous reset. While reset=1 at an edge, all valid bits go to 0 and all data registers go to 0.
  - During reset, in_ready=0, out_valid=0, count=0 and stage_valid=0.
  - Reset mid-operation drops all entries without emitting them.
  - State per slot i is v[i] (live bit) and d[i] (WIDTH bits).
- Per-slot terms:
  - live[i] = v[i] & ~flush[i].
  - leave[S-1] = live[S-1] & out_ready.
  - leave[i] (i<S-1) = live[i] & take[i+1].
  - take[i] (i>0) = ~flush[i] & (~v[i] | leave[i] | flush-free empty). Precisely: take[i] = ~flush[i] & (~v[i] | leave[i]).
  - take[0] = ~flush[0] & (~v[0] | leave[0]) & ~reset.
- Outputs:
  - in_ready = take[0].
  - out_valid = live[S-1].
  - out_data = d[S-1].
  - stage_valid = v & ~flush, i.e. combinational live bits.
  - count = popcount of stage_valid.
- Next state per slot:
  - If flush[i]: v[i] <= 0. The slot captures nothing this cycle, and any entry that would move into it stays in slot i-1.
  - Else if take[i]:
    - i=0: v[0] <= in_valid, d[0] <= in_data (d only written when in_valid).
    - i>0: v[i] <= live[i-1], d[i] <= d[i-1] (d only written when live[i-1]).
  - Else: hold.
- A flushed entry never transfers downstream and never appears on out_valid.
- The handshake completes only on in_valid&in_ready or out_valid&out_ready. in_ready may depend on out_ready (combinational ready ripple is permitted). Nothing else is combinational from input to output.
- Latency:
  - With out_ready=1 and no flush, an entry accepted at edge N is presented on out_valid after edge N+STAGES-1.
  - Throughput is 1 entry/cycle.
- Full: all v=1 and out_ready=0 gives in_ready=0 and all slots hold.
- Simultaneous events:
  - Accept and emit in the same cycle is allowed when full; count is unchanged.
  - flush[S-1] together with out_ready: no transfer, out_valid=0.
  - flush on an empty slot has no effect other than blocking capture.
- STAGES=1: single register slice with in_ready = ~flush[0] & (~v[0] | out_ready).
- No payload width conversion; data is never modified.

Test Plan:
- Fill/drain: WIDTH=32, STAGES=4, out_ready=1, push 0x10..0x17 on consecutive cycles -> out_data 0x10..0x17 in order, first one 3 cycles after acceptance, with no gaps.
- Backpressure: out_ready=0 while pushing 0xA0..0xA5 -> 4 accepted, in_ready=0 afterwards, count=4. Raise out_ready -> 0xA0..0xA5 emerge in order, none lost or duplicated.
- Bubble collapse: slots {3,1} live, out_ready=0, in_valid=1 -> slot 1 advances to slot 2, slot 0 captures, count goes 2->3.
- Redirect flush: 4 live entries 1,2,3,4 (oldest=1), flush=4'b0011 for one cycle with out_ready=1 -> entry 1 emitted, then 2 emitted, then 3 and 4 never appear; count drops by 2.
- Flush plus move: slot 3 flushed while slot 2 is live and out_ready=1 -> slot 2 holds that cycle, then emerges next cycle, and out_valid=0 during the flush cycle.
- Reset mid-stream: reset=1 for one edge with 3 live entries -> count=0, out_valid=0, in_ready=0 during reset. After release, a push of 0x55 emerges alone 3 cycles later.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready slot chain with bubble collapse, per-slot flush and occupancy export.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CW     = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] stage_valid,
  output logic [CW-1:0]     count
);
  logic [STAGES-1:0] v, live, leave;
  logic [STAGES:0]   take;
  logic [WIDTH-1:0]  d [STAGES];
  // take[STAGES] stands in for the downstream consumer so the ripple loop is uniform
  always_comb begin
    live = v & ~flush;
    leave = '0;
    take = '0;
    take[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      leave[i] = live[i] & take[i+1];
      take[i] = ~flush[i] & (~v[i] | leave[i]) & ~(i == 0 && reset);
    end
  end
  assign in_ready    = take[0];
  assign stage_valid = live & {STAGES{~reset}};
  assign out_valid   = stage_valid[STAGES-1];
  assign out_data    = d[STAGES-1];
  always_comb begin
    count = '0;
    for (int i = 0; i < STAGES; i++) count += CW'(stage_valid[i]);
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic             sv;
    logic [WIDTH-1:0] sd;
    if (i == 0) begin : g_head
      assign sv = in_valid;
      assign sd = in_data;
    end else begin : g_body
      assign sv = live[i-1];
      assign sd = d[i-1];
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        v[i] <= 1'b0;
        d[i] <= '0;
      end else if (flush[i]) begin
        v[i] <= 1'b0;
      end else if (take[i]) begin
        v[i] <= sv;
        if (sv) d[i] <= sd;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed table-driven checks of the 4-slot, 32-bit elastic chain.
module tb_pipe_stage_chain;
  logic        clk = 0, reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [3:0]  flush, stage_valid;
  logic [2:0]  count;
  int nchk = 0, nbad = 0;

  pipe_stage_chain #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .stage_valid(stage_valid), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, iv; logic [31:0] id; logic ordy; logic [3:0] fl;
    logic e_ir, e_ov; logic [31:0] e_od; logic [2:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, iv, input logic [31:0] id, input logic ordy,
                     input logic [3:0] fl, input logic e_ir, e_ov,
                     input logic [31:0] e_od, input logic [2:0] e_cnt);
    tbl.push_back('{rst, iv, id, ordy, fl, e_ir, e_ov, e_od, e_cnt});
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1; in_valid = 0; in_data = 0; out_ready = 0; flush = 0;
    add(1,0,0,0,4'h0, 0,0,0,0);
    add(1,0,0,0,4'h0, 0,0,0,0);
    // fill/drain
    add(0,1,'h10,1,4'h0, 1,0,0,0);
    add(0,1,'h11,1,4'h0, 1,0,0,1);
    add(0,1,'h12,1,4'h0, 1,0,0,2);
    add(0,1,'h13,1,4'h0, 1,0,0,3);
    add(0,1,'h14,1,4'h0, 1,1,'h10,4);
    add(0,1,'h15,1,4'h0, 1,1,'h11,4);
    add(0,1,'h16,1,4'h0, 1,1,'h12,4);
    add(0,1,'h17,1,4'h0, 1,1,'h13,4);
    add(0,0,0,1,4'h0, 1,1,'h14,4);
    add(0,0,0,1,4'h0, 1,1,'h15,3);
    add(0,0,0,1,4'h0, 1,1,'h16,2);
    add(0,0,0,1,4'h0, 1,1,'h17,1);
    // backpressure
    add(0,1,'hA0,0,4'h0, 1,0,0,0);
    add(0,1,'hA1,0,4'h0, 1,0,0,1);
    add(0,1,'hA2,0,4'h0, 1,0,0,2);
    add(0,1,'hA3,0,4'h0, 1,0,0,3);
    add(0,1,'hA4,0,4'h0, 0,1,'hA0,4);
    add(0,1,'hA4,0,4'h0, 0,1,'hA0,4);
    add(0,1,'hA4,1,4'h0, 1,1,'hA0,4);
    add(0,1,'hA5,1,4'h0, 1,1,'hA1,4);
    add(0,0,0,1,4'h0, 1,1,'hA2,4);
    add(0,0,0,1,4'h0, 1,1,'hA3,3);
    add(0,0,0,1,4'h0, 1,1,'hA4,2);
    add(0,0,0,1,4'h0, 1,1,'hA5,1);
    // bubble collapse: build slots {3,1}, then push with out_ready=0
    add(0,1,'h31,0,4'h0, 1,0,0,0);
    add(0,0,0,0,4'h0, 1,0,0,1);
    add(0,0,0,0,4'h0, 1,0,0,1);
    add(0,0,0,0,4'h0, 1,0,0,1);
    add(0,1,'h32,0,4'h0, 1,1,'h31,1);
    add(0,0,0,0,4'h0, 1,1,'h31,2);
    add(0,1,'h33,0,4'h0, 1,1,'h31,2);
    add(0,0,0,1,4'h0, 1,1,'h31,3);
    add(0,0,0,1,4'h0, 1,1,'h32,2);
    add(0,0,0,1,4'h0, 1,0,0,1);
    add(0,0,0,1,4'h0, 1,1,'h33,1);
    // redirect flush of the two youngest slots
    add(0,1,'h1,0,4'h0, 1,0,0,0);
    add(0,1,'h2,0,4'h0, 1,0,0,1);
    add(0,1,'h3,0,4'h0, 1,0,0,2);
    add(0,1,'h4,0,4'h0, 1,0,0,3);
    add(0,0,0,1,4'b0011, 0,1,'h1,2);
    add(0,0,0,1,4'h0, 1,1,'h2,1);
    add(0,0,0,1,4'h0, 1,0,0,0);
    add(0,0,0,1,4'h0, 1,0,0,0);
    // flush of the oldest slot while slot 2 wants to move
    add(0,1,'h41,0,4'h0, 1,0,0,0);
    add(0,1,'h42,0,4'h0, 1,0,0,1);
    add(0,0,0,0,4'h0, 1,0,0,2);
    add(0,0,0,0,4'h0, 1,0,0,2);
    add(0,0,0,1,4'b1000, 1,0,0,1);
    add(0,0,0,1,4'h0, 1,0,0,1);
    add(0,0,0,1,4'h0, 1,1,'h42,1);
    // reset mid-stream
    add(0,1,'h61,0,4'h0, 1,0,0,0);
    add(0,1,'h62,0,4'h0, 1,0,0,1);
    add(0,1,'h63,0,4'h0, 1,0,0,2);
    add(1,1,'h99,1,4'h0, 0,0,0,0);
    add(0,1,'h55,1,4'h0, 1,0,0,0);
    add(0,0,0,1,4'h0, 1,0,0,1);
    add(0,0,0,1,4'h0, 1,0,0,1);
    add(0,0,0,1,4'h0, 1,0,0,1);
    add(0,0,0,1,4'h0, 1,1,'h55,1);
    add(0,0,0,1,4'h0, 1,0,0,0);

    for (int k = 0; k < tbl.size(); k++) begin
      reset = tbl[k].rst; in_valid = tbl[k].iv; in_data = tbl[k].id;
      out_ready = tbl[k].ordy; flush = tbl[k].fl;
      #1;
      chk($sformatf("row%0d in_ready", k), 32'(in_ready), 32'(tbl[k].e_ir));
      chk($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
      chk($sformatf("row%0d count", k), 32'(count), 32'(tbl[k].e_cnt));
      if (tbl[k].e_ov) chk($sformatf("row%0d out_data", k), out_data, tbl[k].e_od);
      if (tbl[k].rst) chk($sformatf("row%0d stage_valid", k), 32'(stage_valid), 0);
      tick();
    end
    chk("post_reset_data", out_data, 32'h55);

    // latency: accepted at edge N, visible after edge N+3
    reset = 0; flush = 0; out_ready = 1; in_valid = 1; in_data = 32'h77;
    #1;
    chk("lat_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("lat_edges", n, 3);
    chk("lat_data", out_data, 32'h77);
    tick();
    chk("lat_drained", 32'(count), 0);

    // an entry killed in slot 2 must never reach the output
    out_ready = 0; in_valid = 1; in_data = 32'h81;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("kill_sv_before", 32'(stage_valid), 32'b0100);
    flush = 4'b0100; out_ready = 1;
    #1;
    chk("kill_sv_during", 32'(stage_valid), 0);
    chk("kill_cnt_during", 32'(count), 0);
    tick();
    flush = 0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) n++;
      tick();
    end
    chk("kill_never_out", n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
